// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-code constants and frame FSM states shared by the PS/2 decoder.
package ps2_pkg;

  localparam logic [7:0]  PS2_EXT       = 8'hE0;
  localparam logic [7:0]  PS2_REL       = 8'hF0;
  localparam logic [7:0]  PS2_PAUSE     = 8'hE1;
  localparam int unsigned PS2_PAUSE_LEN = 7;
  localparam int unsigned SKIP_W        = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } ps2_state_t;

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchronizes the raw PS/2 lines, glitch-filters the clock
// and emits a one-cycle strobe on each filtered falling edge.
//   clk, rst_n : system clock, async active-low reset
//   ps2_clk    : raw PS/2 clock pin (async, idle high)
//   ps2_data   : raw PS/2 data pin (async, idle high)
//   fall       : one-cycle strobe, filtered clock went high-to-low
//   data       : synchronized data line, valid to sample on fall
module ps2_line_filter #(
  parameter int unsigned FILTER = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data
);

  localparam int unsigned CW = $clog2(FILTER + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt;
  logic [CW-1:0] cnt;
  logic          flip;

  // FILTER-th consecutive sample at the new level commits the change
  assign flip = (clk_sync[1] != filt) && (cnt == CW'(FILTER - 1));
  assign data = data_sync[1];

  // Synchronizers, run-length filter and fall strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt      <= 1'b1;
      cnt       <= '0;
      fall      <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      fall      <= flip & filt;
      if (clk_sync[1] == filt) begin
        cnt <= '0;
      end else if (flip) begin
        filt <= clk_sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: receives PS/2 keyboard frames and produces the 11-bit
// ps2_key event word; bit 10 toggles on every decoded key event.
//   clk, rst_n : system clock, async active-low reset
//   ps2_clk    : raw PS/2 clock pin
//   ps2_data   : raw PS/2 data pin
//   ps2_key    : {toggle, pressed, extended, scan[7:0]}
//   frame_err  : one-cycle pulse on a parity or stop error
//   busy       : high while a frame is being received
module ps2_key_decoder #(
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 96000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err,
  output logic        busy
);

  import ps2_pkg::*;

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  ps2_state_t        state_q, state_d;
  logic [9:0]        shreg_q, shreg_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              ext_q, ext_d;
  logic              rel_q, rel_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [10:0]       key_d;
  logic              err_d;
  logic              fall;
  logic              data;
  logic [7:0]        rx_byte;
  logic              frame_ok;

  ps2_line_filter #(.FILTER(FILTER)) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall),
    .data     (data)
  );

  // Bits shift in from the top, so after ten bits [7:0]=byte, [8]=parity, [9]=stop
  assign rx_byte  = shreg_q[7:0];
  assign frame_ok = (^shreg_q[8:0]) & shreg_q[9];

  // Frame FSM, timeout and prefix/skip decode
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    tcnt_d   = tcnt_q;
    ext_d    = ext_q;
    rel_d    = rel_q;
    skip_d   = skip_q;
    key_d    = ps2_key;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall && !data) begin
          shreg_d  = '0;
          bitcnt_d = '0;
          tcnt_d   = '0;
          state_d  = RECV;
        end
      end
      RECV: begin
        // A fall on the expiry cycle still counts as a bit
        if (fall) begin
          shreg_d  = {data, shreg_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          tcnt_d   = '0;
          if (bitcnt_q == 4'd9) state_d = DONE;
        end else if (tcnt_q == TW'(TIMEOUT)) begin
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!frame_ok) begin
          err_d  = 1'b1;
          ext_d  = 1'b0;
          rel_d  = 1'b0;
          skip_d = '0;
        end else if (skip_q != '0) begin
          skip_d = skip_q - SKIP_W'(1);
        end else if (rx_byte == PS2_PAUSE) begin
          skip_d = SKIP_W'(PS2_PAUSE_LEN);
        end else if (rx_byte == PS2_EXT) begin
          ext_d = 1'b1;
        end else if (rx_byte == PS2_REL) begin
          rel_d = 1'b1;
        end else begin
          key_d = {~ps2_key[10], ~rel_q, ext_q, rx_byte};
          ext_d = 1'b0;
          rel_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      tcnt_q    <= '0;
      ext_q     <= 1'b0;
      rel_q     <= 1'b0;
      skip_q    <= '0;
      ps2_key   <= '0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      tcnt_q    <= tcnt_d;
      ext_q     <= ext_d;
      rel_q     <= rel_d;
      skip_q    <= skip_d;
      ps2_key   <= key_d;
      frame_err <= err_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: drives PS/2 frames into ps2_key_decoder; expected events
// are queued at stimulus time and a monitor compares every ps2_key change and
// frame_err pulse against the queue.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int unsigned FILTER   = 8;
  localparam int unsigned TIMEOUT  = 960;
  localparam int unsigned HALF_BIT = 40;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  typedef struct packed {
    logic        is_err;
    logic [10:0] key;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          waited;
  logic        saw_busy;
  logic [10:0] prev_key = '0;

  ps2_key_decoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #10.417 clk = ~clk;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad);
    return {1'b1, (~^b) ^ bad, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_clks(HALF_BIT);
      ps2_clk = 1'b0;
      wait_clks(HALF_BIT);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad);
    send_bits(frame_bits(b, bad), 11);
    ps2_data = 1'b1;
    wait_clks(200);
  endtask

  task automatic expect_key(input logic [10:0] k);
    exp_q.push_back('{is_err: 1'b0, key: k});
  endtask

  task automatic expect_err();
    exp_q.push_back('{is_err: 1'b1, key: 11'h0});
  endtask

  // Monitor: every frame_err pulse and ps2_key change must match the queue head
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_key = '0;
    end else begin
      if (frame_err) begin
        n_cmp++;
        if (exp_q.size() == 0 || !exp_q[0].is_err) begin
          n_bad++;
          $display("FAIL frame_err: got unexpected pulse, required none");
        end else begin
          void'(exp_q.pop_front());
        end
      end
      if (ps2_key !== prev_key) begin
        if (exp_q.size() == 0 || exp_q[0].is_err) begin
          n_cmp++;
          n_bad++;
          $display("FAIL ps2_key_update: got %0h, required no change from %0h", ps2_key, prev_key);
        end else begin
          e = exp_q.pop_front();
          check("ps2_key", 32'(ps2_key), 32'(e.key));
        end
        prev_key = ps2_key;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish, required finish before 5 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait_clks(5);
    check("reset_ps2_key", 32'(ps2_key), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    wait_clks(20);

    // Make and break of 0x1C
    expect_key(11'h61C); send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0);
    expect_key(11'h01C); send_frame(8'h1C, 1'b0);

    // Extended make and break
    send_frame(8'hE0, 1'b0);
    expect_key(11'h775); send_frame(8'h75, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    expect_key(11'h175); send_frame(8'h75, 1'b0);

    // Parity error, then an error clearing a pending E0
    expect_err(); send_frame(8'h1C, 1'b1);
    send_frame(8'hE0, 1'b0);
    expect_err(); send_frame(8'h33, 1'b1);
    expect_key(11'h675); send_frame(8'h75, 1'b0);

    // Abandoned frame: five bits then the clock stays high
    send_bits(frame_bits(8'h55, 1'b0), 5);
    ps2_data = 1'b1;
    check("timeout_busy_mid_frame", 32'(busy), 32'h1);
    waited = 0;
    while (busy && waited < 4 * TIMEOUT) begin
      wait_clks(1);
      waited++;
    end
    check("timeout_busy_low", 32'(busy), 32'h0);
    check("timeout_not_early", 32'(waited > int'(TIMEOUT) - 100), 32'h1);
    wait_clks(100);
    expect_key(11'h229); send_frame(8'h29, 1'b0);

    // 7-cycle clock glitch with data low must not start a frame
    saw_busy = 1'b0;
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_clks(7);
    ps2_clk = 1'b1;
    repeat (40) begin
      wait_clks(1);
      saw_busy |= busy;
    end
    ps2_data = 1'b1;
    check("glitch7_ignored", 32'(saw_busy), 32'h0);

    // 8-cycle low pulse is a real edge and starts a frame
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_clks(8);
    ps2_clk = 1'b1;
    wait_clks(30);
    ps2_data = 1'b1;
    check("low8_starts_frame", 32'(busy), 32'h1);
    waited = 0;
    while (busy && waited < 4 * TIMEOUT) begin
      wait_clks(1);
      waited++;
    end
    check("low8_timeout_busy_low", 32'(busy), 32'h0);
    wait_clks(100);

    // Pause sequence produces no event; the next key does
    send_frame(8'hE1, 1'b0);
    send_frame(8'h14, 1'b0);
    send_frame(8'h77, 1'b0);
    send_frame(8'hE1, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h14, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h77, 1'b0);
    expect_key(11'h61C); send_frame(8'h1C, 1'b0);

    // Reset asserted during bit 4
    send_bits(frame_bits(8'h5A, 1'b0), 5);
    ps2_data = 1'b1;
    wait_clks(10);
    check("midframe_busy_before_reset", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_busy", 32'(busy), 32'h0);
    check("midframe_reset_ps2_key", 32'(ps2_key), 32'h0);
    wait_clks(10);
    rst_n = 1'b1;
    wait_clks(100);
    check("after_reset_busy", 32'(busy), 32'h0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
